// File: rtl/lcd_bus_scheduler_pkg.sv
// Purpose: shared types and constants for the LCD bus scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, HD44780 init ROM lookup, RS encodings.
package lcd_sched_pkg;

    typedef enum logic [2:0] {
        INIT_LOAD,
        INIT_WAIT,
        INIT_DLY,
        IDLE,
        WAIT_DONE,
        SETTLE,
        ACK
    } state_t;

    localparam int   INIT_LEN = 5;
    localparam logic RS_CMD   = 1'b0;
    localparam logic RS_CHAR  = 1'b1;

    // Power-up sequence: 8-bit/2-line/5x8, display on, clear, entry mode, home.
    function automatic logic [7:0] initByte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h38;
            3'd1:    b = 8'h0C;
            3'd2:    b = 8'h01;
            3'd3:    b = 8'h06;
            3'd4:    b = 8'h80;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lcd_bus_scheduler_if.sv
// Purpose: bundle of requester-side and LCD-controller-side signals of the scheduler.
// Latency: n/a (wiring only).
// Backpressure: requests are level-held until oACK; controller start is held until iLCD_DONE.
//
// Names keep the scheduler's point of view (i* = into scheduler, o* = out of scheduler).
// master: the scheduler. slave: the requesters plus the LCD controller.
interface lcd_bus_scheduler_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   iREQ;
    logic [NREQ-1:0]   iREQ_RS;
    logic [8*NREQ-1:0] iREQ_DATA;
    logic [NREQ-1:0]   oACK;
    logic [7:0]        oLCD_DATA;
    logic              oLCD_RS;
    logic              oLCD_START;
    logic              iLCD_DONE;
    logic              oINIT_DONE;
    logic              oBUSY;

    modport master (
        input  iREQ, iREQ_RS, iREQ_DATA, iLCD_DONE,
        output oACK, oLCD_DATA, oLCD_RS, oLCD_START, oINIT_DONE, oBUSY
    );

    modport slave (
        output iREQ, iREQ_RS, iREQ_DATA, iLCD_DONE,
        input  oACK, oLCD_DATA, oLCD_RS, oLCD_START, oINIT_DONE, oBUSY
    );
endinterface

// File: rtl/lcd_bus_scheduler_rr_arbiter.sv
// Purpose: round-robin winner search over the request vector, starting at iPTR.
// Latency: combinational, 0 cycles.
// Backpressure: none; the parent decides when the grant is consumed.
//
// Ports: iREQ request levels, iPTR search start, oGNT winner index, oVLD any request.
module lcd_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] iREQ,
    input  logic [PW-1:0]   iPTR,
    output logic [PW-1:0]   oGNT,
    output logic            oVLD
);
    int idx;

    // Walk offsets from farthest to nearest so the nearest asserted
    // requester (counting up from iPTR with wrap) is the last write.
    always_comb begin
        oVLD = 1'b0;
        oGNT = '0;
        idx  = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(iPTR) + k) % NREQ;
            if (iREQ[idx]) begin
                oVLD = 1'b1;
                oGNT = PW'(idx);
            end
        end
    end
endmodule

// File: rtl/lcd_bus_scheduler.sv
// Purpose: runs the HD44780 init sequence, then round-robin shares one LCD controller between NREQ requesters.
// Latency: grant to oLCD_START 1 cycle; command completes controller time + DLY_CYCLES + 3 cycles.
// Backpressure: requests stay pending until oACK; oLCD_START held until iLCD_DONE.
//
// Ports: iCLK, iRST_N (async active-low), bus (master modport): requester iREQ/iREQ_RS/iREQ_DATA/oACK,
// controller oLCD_DATA/oLCD_RS/oLCD_START/iLCD_DONE, status oINIT_DONE/oBUSY. All outputs registered.
module lcd_bus_scheduler
    import lcd_sched_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int DLY_CYCLES = 262143,
    parameter int DLY_W      = 18
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    lcd_bus_scheduler_if.master  bus
);
    localparam int              PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DLY_CYCLES - 1);
    localparam logic [2:0]      INIT_LAST = 3'(INIT_LEN - 1);

    state_t           state;
    logic [2:0]       initIdx;
    logic [DLY_W-1:0] dlyCnt;
    logic [PW-1:0]    rrPtr;
    logic [PW-1:0]    gntIdxQ;
    logic [PW-1:0]    gntIdx;
    logic             gntVld;
    logic [PW-1:0]    nextPtr;

    lcd_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) uArb (
        .iREQ (bus.iREQ),
        .iPTR (rrPtr),
        .oGNT (gntIdx),
        .oVLD (gntVld)
    );

    assign nextPtr = (int'(gntIdx) == NREQ - 1) ? '0 : gntIdx + 1'b1;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state          <= INIT_LOAD;
            initIdx        <= '0;
            dlyCnt         <= '0;
            rrPtr          <= '0;
            gntIdxQ        <= '0;
            bus.oACK       <= '0;
            bus.oLCD_DATA  <= '0;
            bus.oLCD_RS    <= RS_CMD;
            bus.oLCD_START <= 1'b0;
            bus.oINIT_DONE <= 1'b0;
            bus.oBUSY      <= 1'b1;
        end else begin
            // oACK is a single-cycle pulse; only the SETTLE exit sets a bit.
            bus.oACK <= '0;
            case (state)
                INIT_LOAD: begin
                    bus.oLCD_DATA  <= initByte(initIdx);
                    bus.oLCD_RS    <= RS_CMD;
                    bus.oLCD_START <= 1'b1;
                    state          <= INIT_WAIT;
                end
                INIT_WAIT: begin
                    if (bus.iLCD_DONE) begin
                        bus.oLCD_START <= 1'b0;
                        state          <= INIT_DLY;
                    end
                end
                INIT_DLY: begin
                    if (dlyCnt == DLY_LAST) begin
                        dlyCnt <= '0;
                        if (initIdx == INIT_LAST) begin
                            bus.oINIT_DONE <= 1'b1;
                            bus.oBUSY      <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            initIdx <= initIdx + 3'd1;
                            state   <= INIT_LOAD;
                        end
                    end else begin
                        dlyCnt <= dlyCnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (gntVld) begin
                        // Byte and RS are captured here; the requester may change them afterwards.
                        gntIdxQ        <= gntIdx;
                        rrPtr          <= nextPtr;
                        bus.oLCD_DATA  <= bus.iREQ_DATA[int'(gntIdx)*8 +: 8];
                        bus.oLCD_RS    <= bus.iREQ_RS[gntIdx];
                        bus.oLCD_START <= 1'b1;
                        bus.oBUSY      <= 1'b1;
                        state          <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (bus.iLCD_DONE) begin
                        bus.oLCD_START <= 1'b0;
                        state          <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (dlyCnt == DLY_LAST) begin
                        dlyCnt            <= '0;
                        bus.oACK[gntIdxQ] <= 1'b1;
                        state             <= ACK;
                    end else begin
                        dlyCnt <= dlyCnt + 1'b1;
                    end
                end
                ACK: begin
                    // Skipping arbitration during the ack cycle gives the requester
                    // one cycle to drop or replace its request.
                    bus.oBUSY <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= INIT_LOAD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Purpose: directed self-checking bench for lcd_bus_scheduler with a small LCD controller model.
// Latency: controller model raises done 3 cycles after start, settle is 4 cycles.
// Backpressure: requesters hold their command until oACK, as the scheduler expects.
module tb_lcd_bus_scheduler;
    localparam int NREQ = 2;
    localparam int DLY  = 4;
    localparam int DW   = 3;

    logic iCLK   = 1'b0;
    logic iRST_N = 1'b0;
    always #5 iCLK = ~iCLK;

    lcd_bus_scheduler_if #(.NREQ(NREQ)) bus();

    lcd_bus_scheduler #(
        .NREQ       (NREQ),
        .DLY_CYCLES (DLY),
        .DLY_W      (DW)
    ) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .bus    (bus)
    );

    logic modelDone = 1'b0;
    logic strayDone = 1'b0;
    assign bus.iLCD_DONE = modelDone | strayDone;

    int nChecks = 0;
    int nFail   = 0;
    int cyc     = 0;
    always @(posedge iCLK) cyc++;

    logic [7:0] initRom [5] = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};

    // Controller model: done pulses in the 3rd cycle after start is seen.
    int modelCnt = 0;
    always @(posedge iCLK) begin
        #1;
        if (!iRST_N || !bus.oLCD_START) begin
            modelCnt  = 0;
            modelDone = 1'b0;
        end else if (!modelDone) begin
            if (modelCnt == 2) modelDone = 1'b1;
            else               modelCnt++;
        end
    end

    // Monitor: log each start rising edge as {rs, data} and count ack pulses.
    logic [8:0] startLog [$];
    int         ackCount [NREQ];
    logic       prevStart = 1'b0;
    always @(negedge iCLK) begin
        if (bus.oLCD_START && !prevStart) startLog.push_back({bus.oLCD_RS, bus.oLCD_DATA});
        prevStart = bus.oLCD_START;
        for (int i = 0; i < NREQ; i++) if (bus.oACK[i]) ackCount[i]++;
    end

    task automatic clearLogs();
        startLog.delete();
        for (int i = 0; i < NREQ; i++) ackCount[i] = 0;
    endtask

    task automatic waitInitDone(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge iCLK);
            if (bus.oINIT_DONE) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        iRST_N        = 1'b0;
        bus.iREQ      = '0;
        bus.iREQ_RS   = '0;
        bus.iREQ_DATA = '0;
        @(negedge iCLK);
        nChecks++;
        if ({bus.oLCD_DATA, bus.oLCD_RS, bus.oLCD_START, bus.oACK, bus.oINIT_DONE, bus.oBUSY} !== 14'b00000000_0_0_00_0_1) begin
            nFail++;
            $display("FAIL reset_values: got data=%h rs=%b start=%b ack=%b init=%b busy=%b, expected 00/0/0/00/0/1",
                     bus.oLCD_DATA, bus.oLCD_RS, bus.oLCD_START, bus.oACK, bus.oINIT_DONE, bus.oBUSY);
        end
        @(posedge iCLK);
        clearLogs();
        @(negedge iCLK);
        iRST_N = 1'b1;
        waitInitDone(ok);
        nChecks++;
        if (ok !== 1'b1) begin nFail++; $display("FAIL init_done_timeout: got %b expected 1", ok); end
        nChecks++;
        if (bus.oBUSY !== 1'b0) begin nFail++; $display("FAIL init_busy_low: got %b expected 0", bus.oBUSY); end
        repeat (2) @(negedge iCLK);
        nChecks++;
        if (startLog.size() !== 5) begin nFail++; $display("FAIL init_count: got %0d expected 5", startLog.size()); end
        for (int i = 0; i < 5 && i < startLog.size(); i++) begin
            nChecks++;
            if (startLog[i] !== {1'b0, initRom[i]}) begin
                nFail++;
                $display("FAIL init_byte%0d: got %h expected %h", i, startLog[i], {1'b0, initRom[i]});
            end
        end
        nChecks++;
        if (ackCount[0] + ackCount[1] !== 0) begin nFail++; $display("FAIL init_no_ack: got %0d expected 0", ackCount[0] + ackCount[1]); end
    endtask

    task automatic test_single();
        int doneCyc = -1;
        int ackCyc  = -1;
        logic [1:0] ackVal = '0;
        @(posedge iCLK);
        clearLogs();
        @(negedge iCLK);
        bus.iREQ_RS[0]      = 1'b1;
        bus.iREQ_DATA[7:0]  = 8'h41;
        bus.iREQ[0]         = 1'b1;
        @(negedge iCLK);
        nChecks++;
        if ({bus.oLCD_START, bus.oLCD_RS, bus.oLCD_DATA} !== {1'b1, 1'b1, 8'h41}) begin
            nFail++;
            $display("FAIL single_start: got start=%b rs=%b data=%h expected 1/1/41", bus.oLCD_START, bus.oLCD_RS, bus.oLCD_DATA);
        end
        for (int n = 0; n < 100; n++) begin
            @(negedge iCLK);
            if (bus.iLCD_DONE && doneCyc < 0) doneCyc = cyc;
            if (bus.oACK != '0) begin
                ackCyc = cyc;
                ackVal = bus.oACK;
                bus.iREQ[0] = 1'b0;
                break;
            end
        end
        // done cycle, then DLY settle cycles, then the ack cycle
        nChecks++;
        if (ackCyc < 0 || doneCyc < 0 || ackCyc - doneCyc !== DLY + 1) begin
            nFail++;
            $display("FAIL single_ack_timing: got distance %0d (done %0d ack %0d) expected %0d", ackCyc - doneCyc, doneCyc, ackCyc, DLY + 1);
        end
        nChecks++;
        if (ackVal !== 2'b01) begin nFail++; $display("FAIL single_ack_bit: got %b expected 01", ackVal); end
        @(negedge iCLK);
        nChecks++;
        if ({bus.oACK, bus.oBUSY} !== 3'b000) begin
            nFail++;
            $display("FAIL single_after_ack: got ack=%b busy=%b expected 00/0", bus.oACK, bus.oBUSY);
        end
        repeat (3) @(negedge iCLK);
        nChecks++;
        if (ackCount[0] !== 1 || ackCount[1] !== 0) begin
            nFail++;
            $display("FAIL single_ack_count: got %0d/%0d expected 1/0", ackCount[0], ackCount[1]);
        end
    endtask

    task automatic test_init_pending();
        bit ok;
        bit acked = 1'b0;
        @(posedge iCLK);
        iRST_N = 1'b0;
        clearLogs();
        bus.iREQ_RS[1]      = 1'b1;
        bus.iREQ_DATA[15:8] = 8'h55;
        bus.iREQ[1]         = 1'b1;
        @(negedge iCLK);
        iRST_N = 1'b1;
        waitInitDone(ok);
        nChecks++;
        if (ok !== 1'b1) begin nFail++; $display("FAIL pending_init_timeout: got %b expected 1", ok); end
        nChecks++;
        if (ackCount[1] !== 0) begin nFail++; $display("FAIL pending_no_early_ack: got %0d expected 0", ackCount[1]); end
        @(negedge iCLK);
        nChecks++;
        if ({bus.oLCD_START, bus.oLCD_RS, bus.oLCD_DATA} !== {1'b1, 1'b1, 8'h55}) begin
            nFail++;
            $display("FAIL pending_first_idle_grant: got start=%b rs=%b data=%h expected 1/1/55", bus.oLCD_START, bus.oLCD_RS, bus.oLCD_DATA);
        end
        for (int n = 0; n < 100; n++) begin
            @(negedge iCLK);
            if (bus.oACK != '0) begin
                acked = 1'b1;
                bus.iREQ[1] = 1'b0;
                break;
            end
        end
        repeat (3) @(negedge iCLK);
        nChecks++;
        if (acked !== 1'b1 || ackCount[1] !== 1 || ackCount[0] !== 0) begin
            nFail++;
            $display("FAIL pending_ack_once: got acked=%b count=%0d/%0d expected 1, 0/1", acked, ackCount[0], ackCount[1]);
        end
        nChecks++;
        if (startLog.size() !== 6) begin nFail++; $display("FAIL pending_start_count: got %0d expected 6", startLog.size()); end
    endtask

    task automatic test_back_to_back();
        int order [4];
        int k = 0;
        for (int j = 0; j < 4; j++) order[j] = -1;
        @(posedge iCLK);
        clearLogs();
        @(negedge iCLK);
        bus.iREQ_RS   = 2'b11;
        bus.iREQ_DATA = {8'h31, 8'h30};
        bus.iREQ      = 2'b11;
        for (int n = 0; n < 300 && k < 4; n++) begin
            @(negedge iCLK);
            if (bus.oACK != '0) begin
                order[k] = (bus.oACK == 2'b10) ? 1 : 0;
                k++;
                if (k == 4) bus.iREQ = '0;
            end
        end
        nChecks++;
        if (k !== 4) begin nFail++; $display("FAIL b2b_ack_count: got %0d expected 4", k); end
        for (int j = 0; j < 4; j++) begin
            nChecks++;
            if (order[j] !== j % 2) begin nFail++; $display("FAIL b2b_order%0d: got %0d expected %0d", j, order[j], j % 2); end
        end
        repeat (3) @(negedge iCLK);
        nChecks++;
        if (startLog.size() !== 4) begin nFail++; $display("FAIL b2b_start_count: got %0d expected 4", startLog.size()); end
        for (int j = 0; j < 4 && j < startLog.size(); j++) begin
            nChecks++;
            if (startLog[j] !== {1'b1, ((j % 2) != 0) ? 8'h31 : 8'h30}) begin
                nFail++;
                $display("FAIL b2b_data%0d: got %h expected %h", j, startLog[j], {1'b1, ((j % 2) != 0) ? 8'h31 : 8'h30});
            end
        end
    endtask

    task automatic test_latch_and_stray();
        bit held  = 1'b1;
        bit acked = 1'b0;
        @(posedge iCLK);
        clearLogs();
        @(negedge iCLK);
        bus.iREQ_RS[0]     = 1'b1;
        bus.iREQ_DATA[7:0] = 8'h41;
        bus.iREQ[0]        = 1'b1;
        @(negedge iCLK);
        nChecks++;
        if ({bus.oLCD_START, bus.oLCD_DATA} !== {1'b1, 8'h41}) begin
            nFail++;
            $display("FAIL latch_start: got start=%b data=%h expected 1/41", bus.oLCD_START, bus.oLCD_DATA);
        end
        bus.iREQ_DATA[7:0] = 8'h42;
        for (int n = 0; n < 100; n++) begin
            @(negedge iCLK);
            if (bus.oLCD_DATA !== 8'h41) held = 1'b0;
            if (bus.oACK != '0) begin
                acked = 1'b1;
                bus.iREQ[0] = 1'b0;
                break;
            end
        end
        nChecks++;
        if ({acked, held} !== 2'b11) begin nFail++; $display("FAIL latch_data_held: got acked=%b held=%b expected 1/1", acked, held); end
        for (int s = 0; s < 3; s++) begin
            @(negedge iCLK);
            strayDone = 1'b1;
            @(negedge iCLK);
            strayDone = 1'b0;
        end
        @(negedge iCLK);
        nChecks++;
        if ({bus.oLCD_START, bus.oBUSY, bus.oACK, bus.oLCD_DATA} !== {1'b0, 1'b0, 2'b00, 8'h41}) begin
            nFail++;
            $display("FAIL stray_done_ignored: got start=%b busy=%b ack=%b data=%h expected 0/0/00/41",
                     bus.oLCD_START, bus.oBUSY, bus.oACK, bus.oLCD_DATA);
        end
        nChecks++;
        if (startLog.size() !== 1 || ackCount[0] !== 1) begin
            nFail++;
            $display("FAIL stray_no_transfer: got starts=%0d acks=%0d expected 1/1", startLog.size(), ackCount[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit started = 1'b0;
        @(negedge iCLK);
        bus.iREQ_RS[0]     = 1'b1;
        bus.iREQ_DATA[7:0] = 8'h41;
        bus.iREQ[0]        = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge iCLK);
            if (bus.oLCD_START) begin
                started = 1'b1;
                break;
            end
        end
        @(negedge iCLK);
        iRST_N   = 1'b0;
        bus.iREQ = '0;
        #1;
        nChecks++;
        if ({started, bus.oLCD_DATA, bus.oLCD_RS, bus.oLCD_START, bus.oACK, bus.oINIT_DONE, bus.oBUSY} !== 15'b1_00000000_0_0_00_0_1) begin
            nFail++;
            $display("FAIL midreset_values: got started=%b data=%h rs=%b start=%b ack=%b init=%b busy=%b expected 1, 00/0/0/00/0/1",
                     started, bus.oLCD_DATA, bus.oLCD_RS, bus.oLCD_START, bus.oACK, bus.oINIT_DONE, bus.oBUSY);
        end
        @(posedge iCLK);
        clearLogs();
        @(negedge iCLK);
        iRST_N = 1'b1;
        waitInitDone(ok);
        repeat (2) @(negedge iCLK);
        nChecks++;
        if (ok !== 1'b1 || startLog.size() !== 5) begin
            nFail++;
            $display("FAIL midreset_reinit: got done=%b starts=%0d expected 1/5", ok, startLog.size());
        end
        nChecks++;
        if (startLog.size() == 0 || startLog[0] !== 9'h038) begin
            nFail++;
            $display("FAIL midreset_first_byte: got %h expected 038", (startLog.size() == 0) ? 9'h1FF : startLog[0]);
        end
        nChecks++;
        if (ackCount[0] + ackCount[1] !== 0) begin nFail++; $display("FAIL midreset_no_ack: got %0d expected 0", ackCount[0] + ackCount[1]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_init_pending();
        test_back_to_back();
        test_latch_and_stray();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end of test, expected completion");
        $fatal(1);
    end
endmodule
